// File: rtl/vehicle_sensor_if.sv
// Country-road vehicle sensor interface: synchronizes and debounces the loop detector,
// counts queued vehicles and raises the vehicle-waiting request X for the controller.
// Optional build macro: SENSOR_STUCK_DET_EN enables the loop stuck-high fault detector.
module vehicle_sensor_if #(
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned DEPART_CYC   = 3,
    parameter int unsigned MAX_Q        = 15,
    parameter int unsigned STUCK_CYC    = 64
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       loop_raw,
    input  logic [1:0] cntry,
    output logic       X,
    output logic [3:0] queue_cnt,
    output logic       ovf,
    output logic       stuck
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned TmW = $clog2(DEPART_CYC + 1);

    typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

    logic [1:0]     rst_sync_q;
    logic           rst_n;
    logic [1:0]     sync_q;
    logic           loop_s;
    logic           db_q, db_d;
    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic           db_prev_q;
    logic           arrival, depart, green;
    logic [3:0]     queue_cnt_q, queue_cnt_d;
    logic           ovf_q, ovf_d;
    logic [TmW-1:0] tmr_q, tmr_d;
    state_e         state_q, state_d;

    // Reset assertion is asynchronous, release is synchronized to clk.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    // Two-flop synchronizer for the asynchronous loop detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], loop_raw};
    end
    assign loop_s = sync_q[1];

    // Debounce: toggle only after DEBOUNCE_CYC consecutive disagreeing samples.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        if (loop_s != db_q) begin
            if (db_cnt_q == DbW'(DEBOUNCE_CYC - 1)) db_d = ~db_q;
            else                                    db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    assign arrival = db_q & ~db_prev_q;
    assign green   = (cntry == 2'd2);
    assign depart  = (state_q == StDrain) && (tmr_q == TmW'(DEPART_CYC - 1)) &&
                     (queue_cnt_q != '0);

    // Queue count: coincident arrival and departure cancel; saturate at MAX_Q.
    always_comb begin
        queue_cnt_d = queue_cnt_q;
        ovf_d       = ovf_q;
        if (arrival && !depart) begin
            if (queue_cnt_q == 4'(MAX_Q)) ovf_d = 1'b1;
            else                          queue_cnt_d = queue_cnt_q + 4'd1;
        end else if (depart && !arrival) begin
            queue_cnt_d = queue_cnt_q - 4'd1;
        end
    end

    // Service FSM; the departure timer only runs while staying in DRAIN.
    always_comb begin
        state_d = state_q;
        tmr_d   = '0;
        unique case (state_q)
            StIdle:  if (arrival) state_d = StWait;
            StWait:  if (green) state_d = StDrain;
            StDrain: begin
                if (queue_cnt_d == '0)  state_d = StIdle;
                else if (!green)        state_d = StWait;
                else                    tmr_d = depart ? '0 : tmr_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q        <= 1'b0;
            db_cnt_q    <= '0;
            db_prev_q   <= 1'b0;
            queue_cnt_q <= '0;
            ovf_q       <= 1'b0;
            tmr_q       <= '0;
            state_q     <= StIdle;
        end else begin
            db_q        <= db_d;
            db_cnt_q    <= db_cnt_d;
            db_prev_q   <= db_q;
            queue_cnt_q <= queue_cnt_d;
            ovf_q       <= ovf_d;
            tmr_q       <= tmr_d;
            state_q     <= state_d;
        end
    end

`ifdef SENSOR_STUCK_DET_EN
    localparam int unsigned StW = $clog2(STUCK_CYC + 1);

    logic [StW-1:0] stuck_cnt_q, stuck_cnt_d;
    logic           stuck_q, stuck_d;

    // Count consecutive debounced-high cycles; flag is sticky until reset.
    always_comb begin
        stuck_cnt_d = '0;
        stuck_d     = stuck_q;
        if (db_q) begin
            if (stuck_cnt_q == StW'(STUCK_CYC - 1)) begin
                stuck_d     = 1'b1;
                stuck_cnt_d = stuck_cnt_q;
            end else begin
                stuck_cnt_d = stuck_cnt_q + 1'b1;
            end
        end
    end

    // Stuck detector registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stuck_cnt_q <= '0;
            stuck_q     <= 1'b0;
        end else begin
            stuck_cnt_q <= stuck_cnt_d;
            stuck_q     <= stuck_d;
        end
    end

    assign stuck = stuck_q;
`else
    logic unused_stuck_cyc;
    assign unused_stuck_cyc = ^STUCK_CYC;
    assign stuck            = 1'b0;
`endif

    // A stuck loop forces a request so the country road is never starved.
    assign X         = (queue_cnt_q != '0) | stuck;
    assign queue_cnt = queue_cnt_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/vehicle_sensor_if.md
VEHICLE_SENSOR_IF -- requirements
Module: vehicle_sensor_if

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 4, number of consecutive stable cycles required to accept a loop level change.
REQ-002 Parameter DEPART_CYC, default 3, cycles per vehicle departure while the country light is green.
REQ-003 Parameter MAX_Q, default 15, queue saturation value (fits queue_cnt width).
REQ-004 Parameter STUCK_CYC, default 64, loop-high cycles before a stuck fault is declared.
REQ-005 clk  input  1  single system clock, rising-edge active.
REQ-006 clear_n  input  1  reset, asynchronous assert, active-low.
REQ-007 loop_raw  input  1  raw country-road loop detector, asynchronous to clk, high = vehicle over loop.
REQ-008 cntry  input  2  country light state from controller (RED=0, YELLOW=1, GREEN=2).
REQ-009 X  output  1  vehicle-waiting request to controller.
REQ-010 queue_cnt  output  4  number of queued vehicles.
REQ-011 ovf  output  1  sticky queue-overflow flag.
REQ-012 stuck  output  1  loop stuck-high fault flag.

Function
REQ-013 loop_raw SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Debounced level loop_db SHALL toggle on the edge at which the synchronized value has differed from loop_db for DEBOUNCE_CYC consecutive edges; any agreeing cycle SHALL clear the debounce count.
REQ-015 An arrival SHALL be a registered 0->1 transition of loop_db, counted on the following edge.
REQ-016 X SHALL rise exactly DEBOUNCE_CYC+3 edges after the first edge sampling loop_raw high, given loop_raw is held high and queue_cnt was 0.
REQ-017 States: IDLE (queue_cnt=0), WAIT (queue_cnt>0, cntry!=GREEN), DRAIN (queue_cnt>0, cntry==GREEN).
REQ-018 IDLE->WAIT on arrival; WAIT->DRAIN when cntry==GREEN; DRAIN->WAIT when cntry!=GREEN; DRAIN->IDLE when queue_cnt reaches 0.
REQ-019 Entering DRAIN SHALL zero the departure timer; in DRAIN one departure (queue_cnt-1) SHALL occur every DEPART_CYC edges.
REQ-020 Leaving DRAIN mid-interval SHALL discard the partial timer count.
REQ-021 Simultaneous arrival and departure SHALL leave queue_cnt unchanged.
REQ-022 Arrival at queue_cnt==MAX_Q SHALL hold queue_cnt at MAX_Q and set ovf; ovf clears only on reset.
REQ-023 Departure SHALL never decrement below 0.
REQ-024 X SHALL equal (queue_cnt!=0), or 1 when stuck is asserted.
REQ-025 cntry value 3 SHALL be treated as not GREEN.

Reset
REQ-026 clear_n low SHALL asynchronously force: queue_cnt=0, X=0, ovf=0, stuck=0, loop_db=0, synchronizer=0, all timers=0, state IDLE.
REQ-027 Reset asserted mid-DRAIN or mid-debounce SHALL abandon the operation; after release the block SHALL behave as from power-up.
REQ-028 Release of clear_n SHALL be synchronized to clk internally.

Configuration
REQ-029 Macro SENSOR_STUCK_DET_EN defined: loop_db high for STUCK_CYC consecutive edges SHALL set stuck (sticky until reset), forcing X=1 (fail-safe service of country road).
REQ-030 Macro SENSOR_STUCK_DET_EN undefined: stuck SHALL be tied 0, no stuck counter SHALL exist, X per queue_cnt only.

Verification
REQ-031 Reset, loop_raw high 10 cycles, cntry=RED -> X rises on edge 7, queue_cnt=1, state WAIT.
REQ-032 loop_raw 3-cycle glitch high -> queue_cnt stays 0, X stays 0.
REQ-033 queue_cnt=3, cntry=GREEN held -> queue_cnt 2,1,0 at edges 3,6,9 after entry; X falls with 0.
REQ-034 16 clean arrivals with cntry=RED -> queue_cnt=15, ovf=1 after the 16th; 2 departures -> 13, ovf still 1.
REQ-035 Arrival counted on same edge as departure at queue_cnt=2 -> queue_cnt remains 2.
REQ-036 With SENSOR_STUCK_DET_EN, loop_raw held high 80 cycles, cntry=GREEN -> stuck=1, X=1 while queue_cnt drains to 0.
